// File: rtl/ball_pkg.sv
// Shared screen geometry, velocity/pixel types and motion states for the ball datapath.
package ball_pkg;

   localparam int unsigned BALL_DIAMETER = 32;
   localparam int unsigned SCREEN_W      = 640;
   localparam int unsigned SCREEN_H      = 480;

   typedef logic signed [10:0] vel_t;
   typedef logic        [10:0] pix_t;

   typedef enum logic {
      STOPPED = 1'b0,
      MOVING  = 1'b1
   } motion_state_t;

endpackage

// File: rtl/friction_step.sv
// Moves one signed velocity component a single unit toward zero; zero stays zero.
module friction_step
   import ball_pkg::*;
(
   input  vel_t vel_i,
   output vel_t vel_o
);

   always_comb begin
      vel_o = vel_i;
      if (vel_i > 11'sd0) begin
         vel_o = vel_i - 11'sd1;
      end else if (vel_i < 11'sd0) begin
         vel_o = vel_i + 11'sd1;
      end
   end

endmodule

// File: rtl/ball_motion.sv
// Ball position/velocity owner: strike start, per-frame integration with edge clamping,
// collision velocity reload. Periodic friction only when BALL_MOTION_FRICTION_EN is defined.
module ball_motion
   import ball_pkg::*;
#(
   parameter int unsigned INIT_X          = 100,
   parameter int unsigned INIT_Y          = 100,
   parameter int unsigned FIXED_SHIFT     = 6,
   parameter int unsigned FRICTION_PERIOD = 4,
   parameter int unsigned POS_MAX_X       = SCREEN_W - BALL_DIAMETER - 1,
   parameter int unsigned POS_MAX_Y       = SCREEN_H - BALL_DIAMETER - 1
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               strike,
   input  logic signed [10:0] strikeVelX,
   input  logic signed [10:0] strikeVelY,
   input  logic               collisionOccurred,
   input  logic signed [10:0] collisionVelX,
   input  logic signed [10:0] collisionVelY,
   output logic        [10:0] ballTopLeftPosX,
   output logic        [10:0] ballTopLeftPosY,
   output logic signed [10:0] ballVelX,
   output logic signed [10:0] ballVelY,
   output logic               moving
);

   localparam int unsigned PosW = 11 + FIXED_SHIFT;
   localparam int unsigned SumW = PosW + 1;

   localparam logic [PosW-1:0] InitXFix = PosW'(INIT_X << FIXED_SHIFT);
   localparam logic [PosW-1:0] InitYFix = PosW'(INIT_Y << FIXED_SHIFT);
   localparam logic [PosW-1:0] MaxXFix  = PosW'(POS_MAX_X << FIXED_SHIFT);
   localparam logic [PosW-1:0] MaxYFix  = PosW'(POS_MAX_Y << FIXED_SHIFT);

   // One extra bit of headroom so both underflow and overflow are visible before clamping.
   function automatic logic [PosW-1:0] integrate(input logic [PosW-1:0] pos,
                                                 input vel_t            vel,
                                                 input logic [PosW-1:0] lim);
      logic signed [SumW-1:0] sum;
      sum = $signed({1'b0, pos}) + $signed({{(SumW-11){vel[10]}}, vel});
      if (sum < 0) begin
         integrate = '0;
      end else if (sum > $signed({1'b0, lim})) begin
         integrate = lim;
      end else begin
         integrate = sum[PosW-1:0];
      end
   endfunction

   motion_state_t   state_q, state_d;
   logic [PosW-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   vel_t            vel_x_q, vel_x_d, vel_y_q, vel_y_d;
   vel_t            vel_x_fric, vel_y_fric;

   friction_step u_fric_x (.vel_i(vel_x_q), .vel_o(vel_x_fric));
   friction_step u_fric_y (.vel_i(vel_y_q), .vel_o(vel_y_fric));

`ifdef BALL_MOTION_FRICTION_EN
   localparam int unsigned CntW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(FRICTION_PERIOD - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
`else
   logic unused_fric;
   assign unused_fric = ^{vel_x_fric, vel_y_fric, FRICTION_PERIOD};
`endif

   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      vel_x_d = vel_x_q;
      vel_y_d = vel_y_q;
`ifdef BALL_MOTION_FRICTION_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         STOPPED: begin
            if (strike && (strikeVelX != 11'sd0 || strikeVelY != 11'sd0)) begin
               vel_x_d = strikeVelX;
               vel_y_d = strikeVelY;
               state_d = MOVING;
`ifdef BALL_MOTION_FRICTION_EN
               cnt_d   = '0;
`endif
            end
         end
         MOVING: begin
            if (vel_x_q == 11'sd0 && vel_y_q == 11'sd0) begin
               state_d = STOPPED;
            end
            if (startOfFrame) begin
               pos_x_d = integrate(pos_x_q, vel_x_q, MaxXFix);
               pos_y_d = integrate(pos_y_q, vel_y_q, MaxYFix);
`ifdef BALL_MOTION_FRICTION_EN
               if (cnt_q == CntLast) begin
                  cnt_d   = '0;
                  vel_x_d = vel_x_fric;
                  vel_y_d = vel_y_fric;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
`endif
            end
            // Collision wins over friction; integration above already used the old velocity.
            if (collisionOccurred) begin
               vel_x_d = collisionVelX;
               vel_y_d = collisionVelY;
            end
         end
         default: state_d = STOPPED;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= STOPPED;
         pos_x_q <= InitXFix;
         pos_y_q <= InitYFix;
         vel_x_q <= '0;
         vel_y_q <= '0;
`ifdef BALL_MOTION_FRICTION_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         vel_x_q <= vel_x_d;
         vel_y_q <= vel_y_d;
`ifdef BALL_MOTION_FRICTION_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign ballTopLeftPosX = pos_x_q[PosW-1:FIXED_SHIFT];
   assign ballTopLeftPosY = pos_y_q[PosW-1:FIXED_SHIFT];
   assign ballVelX        = vel_x_q;
   assign ballVelY        = vel_y_q;
   assign moving          = (state_q == MOVING);

endmodule
